// File: rtl/ibram_pkg.sv
// rtl/ibram_pkg.sv - shared sizes, pointer type and write FSM states for the input-activation BRAM group
package ibram_pkg;
    localparam int NUM_BANKS    = 4;
    localparam int WRITE_DEPTH  = 512;
    localparam int STREAM_WIDTH = 64;
    localparam int ADDR_W       = $clog2(WRITE_DEPTH);

    // Published write pointer: ping-pong half in the MSB, next free word below it.
    typedef struct packed {
        logic              pp;
        logic [ADDR_W-1:0] addr;
    } ibram_ptr_t;

    typedef enum logic [1:0] {IDLE, FILL, SWAP, WAIT_FREE} iwr_state_e;
endpackage

// File: rtl/ibram_half_tracker.sv
// rtl/ibram_half_tracker.sv - full flags for the two ping-pong halves with release-then-set ordering
module ibram_half_tracker (
    input  logic clk,
    input  logic rst,
    input  logic set_valid,
    input  logic set_pp,
    input  logic clr_valid,
    input  logic clr_pp,
    input  logic query_pp,
    output logic query_free
);
    logic [1:0] half_full_q;
    logic [1:0] half_full_d;
    logic [1:0] after_clr;

    // A release lands first so a same-cycle set on that half still leaves it full.
    always_comb begin
        after_clr = half_full_q;
        if (clr_valid) begin
            after_clr[clr_pp] = 1'b0;
        end
        half_full_d = after_clr;
        if (set_valid) begin
            half_full_d[set_pp] = 1'b1;
        end
        query_free = ~after_clr[query_pp];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_full_q <= 2'b00;
        end else begin
            half_full_q <= half_full_d;
        end
    end
endmodule

// File: rtl/iwrite_controller_ibram.sv
// rtl/iwrite_controller_ibram.sv - round-robin writer of the activation stream into the ping-pong bank group
module iwrite_controller_ibram
    import ibram_pkg::*;
#(
    parameter int NUM_BANKS    = 4,
    parameter int WRITE_DEPTH  = 512,
    parameter int STREAM_WIDTH = 64,
    parameter int MAX_TILES    = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [$clog2(WRITE_DEPTH):0]                cfg_words,
    input  logic [$clog2(MAX_TILES):0]                  cfg_num_tiles,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [STREAM_WIDTH-1:0]                     s_act_data,
    input  logic                                        s_act_valid,
    output logic                                        s_act_ready,
    input  logic                                        s_act_last,
    output logic [NUM_BANKS-1:0]                        enaA,
    output logic [NUM_BANKS-1:0]                        weA,
    output logic [$clog2(WRITE_DEPTH):0]                addrA_ping_pong,
    output logic [STREAM_WIDTH-1:0]                     diA,
    output logic [NUM_BANKS-1:0][$clog2(WRITE_DEPTH):0] write_addr_pingpong_data,
    input  logic                                        rd_release_valid,
    input  logic                                        rd_release_pp,
    output logic                                        rd_release_ready,
    output logic                                        tile_done,
    output logic                                        busy
);
    localparam int AW = $clog2(WRITE_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(NUM_BANKS);
    localparam int TW = $clog2(MAX_TILES) + 1;

    iwr_state_e                       state_q, state_d;
    logic                             pp_q, pp_d;
    logic [AW-1:0]                    addr_q, addr_d;
    logic [BW-1:0]                    bank_sel_q, bank_sel_d;
    logic [TW-1:0]                    tile_cnt_q, tile_cnt_d;
    logic [LW-1:0]                    cfg_words_q, cfg_words_d;
    logic [TW-1:0]                    cfg_tiles_q, cfg_tiles_d;
    logic [NUM_BANKS-1:0]             ena_q, ena_d;
    logic [LW-1:0]                    addr_pp_q, addr_pp_d;
    logic [STREAM_WIDTH-1:0]          di_q, di_d;
    logic [NUM_BANKS-1:0][AW-1:0]     wcount_q, wcount_d;
    logic                             flip;
    logic                             other_free;

    ibram_half_tracker u_half_tracker (
        .clk        (clk),
        .rst        (rst),
        .set_valid  (state_q == SWAP),
        .set_pp     (pp_q),
        .clr_valid  (rd_release_valid),
        .clr_pp     (rd_release_pp),
        .query_pp   (~pp_q),
        .query_free (other_free)
    );

    always_comb begin
        state_d     = state_q;
        pp_d        = pp_q;
        addr_d      = addr_q;
        bank_sel_d  = bank_sel_q;
        tile_cnt_d  = tile_cnt_q;
        cfg_words_d = cfg_words_q;
        cfg_tiles_d = cfg_tiles_q;
        ena_d       = '0;
        addr_pp_d   = addr_pp_q;
        di_d        = di_q;
        wcount_d    = wcount_q;
        flip        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_words_d = cfg_words;
                    cfg_tiles_d = cfg_num_tiles;
                    tile_cnt_d  = '0;
                    bank_sel_d  = '0;
                    addr_d      = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (s_act_valid) begin
                    ena_d[bank_sel_q] = 1'b1;
                    addr_pp_d         = {addr_q, pp_q};
                    di_d              = s_act_data;
                    bank_sel_d        = bank_sel_q + BW'(1);
                    if (bank_sel_q == BW'(NUM_BANKS - 1)) begin
                        addr_d = addr_q + AW'(1);
                    end
                    if (s_act_last || (({1'b0, addr_q} == (cfg_words_q - LW'(1))) &&
                                       (bank_sel_q == BW'(NUM_BANKS - 1)))) begin
                        state_d = SWAP;
                    end
                end
            end
            SWAP: begin
                tile_cnt_d = tile_cnt_q + TW'(1);
                if ((tile_cnt_q + TW'(1)) == cfg_tiles_q) begin
                    // The next configuration starts in the half not just filled.
                    flip    = 1'b1;
                    state_d = IDLE;
                end else if (!other_free) begin
                    state_d = WAIT_FREE;
                end else begin
                    flip    = 1'b1;
                    state_d = FILL;
                end
            end
            WAIT_FREE: begin
                if (other_free) begin
                    flip    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts advance as each registered write lands in the BRAM.
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ena_q[b]) begin
                wcount_d[b] = wcount_q[b] + AW'(1);
            end
        end

        if (flip) begin
            pp_d       = ~pp_q;
            addr_d     = '0;
            bank_sel_d = '0;
            wcount_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pp_q        <= 1'b0;
            addr_q      <= '0;
            bank_sel_q  <= '0;
            tile_cnt_q  <= '0;
            cfg_words_q <= '0;
            cfg_tiles_q <= '0;
            ena_q       <= '0;
            addr_pp_q   <= '0;
            di_q        <= '0;
            wcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            pp_q        <= pp_d;
            addr_q      <= addr_d;
            bank_sel_q  <= bank_sel_d;
            tile_cnt_q  <= tile_cnt_d;
            cfg_words_q <= cfg_words_d;
            cfg_tiles_q <= cfg_tiles_d;
            ena_q       <= ena_d;
            addr_pp_q   <= addr_pp_d;
            di_q        <= di_d;
            wcount_q    <= wcount_d;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            write_addr_pingpong_data[b] = {pp_q, wcount_q[b]};
        end
    end

    assign enaA             = ena_q;
    assign weA              = ena_q;
    assign addrA_ping_pong  = addr_pp_q;
    assign diA              = di_q;
    assign cfg_ready        = (state_q == IDLE);
    assign s_act_ready      = (state_q == FILL);
    assign rd_release_ready = 1'b1;
    assign tile_done        = (state_q == SWAP);
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_iwrite_controller_ibram.sv
// tb/tb_iwrite_controller_ibram.sv - directed bench for the ping-pong input BRAM write controller
module tb_iwrite_controller_ibram;
    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       cfg_words;
    logic [8:0]       cfg_num_tiles;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [63:0]      s_act_data;
    logic             s_act_valid;
    logic             s_act_ready;
    logic             s_act_last;
    logic [3:0]       enaA;
    logic [3:0]       weA;
    logic [4:0]       addrA_ping_pong;
    logic [63:0]      diA;
    logic [3:0][4:0]  write_addr_pingpong_data;
    logic             rd_release_valid;
    logic             rd_release_pp;
    logic             rd_release_ready;
    logic             tile_done;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [63:0] mem [4][32];

    iwrite_controller_ibram #(
        .NUM_BANKS(4), .WRITE_DEPTH(16), .STREAM_WIDTH(64), .MAX_TILES(256)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_words(cfg_words), .cfg_num_tiles(cfg_num_tiles),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .s_act_data(s_act_data), .s_act_valid(s_act_valid),
        .s_act_ready(s_act_ready), .s_act_last(s_act_last),
        .enaA(enaA), .weA(weA), .addrA_ping_pong(addrA_ping_pong), .diA(diA),
        .write_addr_pingpong_data(write_addr_pingpong_data),
        .rd_release_valid(rd_release_valid), .rd_release_pp(rd_release_pp),
        .rd_release_ready(rd_release_ready),
        .tile_done(tile_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (enaA != 4'h0) begin
            wr_count++;
            for (int b = 0; b < 4; b++) begin
                if (enaA[b]) mem[b][addrA_ping_pong] = diA;
            end
            checks++;
            if (weA !== enaA || !$onehot(enaA)) begin
                errors++;
                $display("FAIL we_onehot: enaA %0h weA %0h expected equal and one-hot", enaA, weA);
            end
        end
        if (tile_done) done_count++;
    end

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; s_act_valid = 1'b0; s_act_last = 1'b0;
        s_act_data = '0; rd_release_valid = 1'b0; rd_release_pp = 1'b0;
        cfg_words = '0; cfg_num_tiles = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clr_mon();
        #2;
        wr_count = 0;
        done_count = 0;
    endtask

    task automatic send_cfg(input int w, input int t);
        cfg_words = 5'(w); cfg_num_tiles = 9'(t); cfg_valid = 1'b1;
        chk("cfg_ready", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n = 0;
        s_act_valid = 1'b1; s_act_data = d; s_act_last = l;
        while (!s_act_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", s_act_ready, 1);
        @(negedge clk);
        s_act_valid = 1'b0; s_act_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic release_half(input logic p);
        rd_release_valid = 1'b1; rd_release_pp = p;
        @(negedge clk);
        rd_release_valid = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        rdy;
        logic [3:0]  ena;
        logic [4:0]  ap;
        logic [63:0] di;
        logic        done;
        logic        bsy;
        logic        pp;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [10];

    initial begin
        // words=2, tiles=1: cnt nibbles are bank3..bank0 committed word counts.
        tbl[0] = '{1'b1, 64'hD0, 1'b0, 1'b1, 4'h0, 5'd0, 64'h0,  1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 64'hD1, 1'b0, 1'b1, 4'h1, 5'd0, 64'hD0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 64'hD2, 1'b0, 1'b1, 4'h2, 5'd0, 64'hD1, 1'b0, 1'b1, 1'b0, 16'h0001};
        tbl[3] = '{1'b1, 64'hD3, 1'b0, 1'b1, 4'h4, 5'd0, 64'hD2, 1'b0, 1'b1, 1'b0, 16'h0011};
        tbl[4] = '{1'b1, 64'hD4, 1'b0, 1'b1, 4'h8, 5'd0, 64'hD3, 1'b0, 1'b1, 1'b0, 16'h0111};
        tbl[5] = '{1'b1, 64'hD5, 1'b0, 1'b1, 4'h1, 5'd2, 64'hD4, 1'b0, 1'b1, 1'b0, 16'h1111};
        tbl[6] = '{1'b1, 64'hD6, 1'b0, 1'b1, 4'h2, 5'd2, 64'hD5, 1'b0, 1'b1, 1'b0, 16'h1112};
        tbl[7] = '{1'b1, 64'hD7, 1'b0, 1'b1, 4'h4, 5'd2, 64'hD6, 1'b0, 1'b1, 1'b0, 16'h1122};
        tbl[8] = '{1'b0, 64'h0,  1'b0, 1'b0, 4'h8, 5'd2, 64'hD7, 1'b1, 1'b1, 1'b0, 16'h1222};
        tbl[9] = '{1'b0, 64'h0,  1'b0, 1'b0, 4'h0, 5'd0, 64'h0,  1'b0, 1'b0, 1'b1, 16'h0000};

        // Reset state
        do_reset();
        chk("rst_ena", enaA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tile_done, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_ready", s_act_ready, 0);
        chk("rst_rel_ready", rd_release_ready, 1);
        for (int b = 0; b < 4; b++) chk($sformatf("rst_ptr%0d", b), write_addr_pingpong_data[b], 0);

        // 1: single two-word tile, cycle-by-cycle table
        send_cfg(2, 1);
        for (int i = 0; i < 10; i++) begin
            s_act_valid = tbl[i].v; s_act_data = tbl[i].d; s_act_last = tbl[i].l;
            chk($sformatf("t1_rdy[%0d]", i), s_act_ready, tbl[i].rdy);
            chk($sformatf("t1_ena[%0d]", i), enaA, tbl[i].ena);
            chk($sformatf("t1_done[%0d]", i), tile_done, tbl[i].done);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].bsy);
            if (tbl[i].ena != 4'h0) begin
                chk($sformatf("t1_addr[%0d]", i), addrA_ping_pong, tbl[i].ap);
                chk($sformatf("t1_di[%0d]", i), diA, tbl[i].di);
            end
            for (int b = 0; b < 4; b++)
                chk($sformatf("t1_ptr%0d[%0d]", b, i), write_addr_pingpong_data[b],
                    {tbl[i].pp, tbl[i].cnt[b*4 +: 4]});
            @(negedge clk);
        end

        // 2: both halves full stalls the stream until half 0 is released
        do_reset(); send_cfg(1, 3); clr_mon();
        for (int b = 0; b < 4; b++) send_beat(64'h200 + 64'(b), 1'b0);
        for (int b = 0; b < 4; b++) send_beat(64'h204 + 64'(b), 1'b0);
        repeat (4) @(negedge clk);
        chk("t2_stall_ready", s_act_ready, 0);
        chk("t2_stall_busy", busy, 1);
        #2;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t2_half0_b%0d", b), mem[b][0], 64'h200 + 64'(b));
            chk($sformatf("t2_half1_b%0d", b), mem[b][1], 64'h204 + 64'(b));
        end
        release_half(1'b0);
        chk("t2_resume_ready", s_act_ready, 1);
        for (int b = 0; b < 4; b++) send_beat(64'h208 + 64'(b), 1'b0);
        wait_idle(); #2;
        for (int b = 0; b < 4; b++) chk($sformatf("t2_tile2_b%0d", b), mem[b][0], 64'h208 + 64'(b));
        chk("t2_done_count", done_count, 3);
        chk("t2_wr_count", wr_count, 12);

        // 3: release during SWAP skips WAIT_FREE; same-half release loses to the set
        do_reset(); send_cfg(1, 3); clr_mon();
        for (int b = 0; b < 4; b++) send_beat(64'h300 + 64'(b), 1'b0);
        for (int b = 0; b < 4; b++) send_beat(64'h304 + 64'(b), 1'b0);
        chk("t3_swap_done", tile_done, 1);
        release_half(1'b0);
        chk("t3_direct_fill", s_act_ready, 1);
        for (int b = 0; b < 4; b++) send_beat(64'h308 + 64'(b), 1'b0);
        chk("t3_swap2_done", tile_done, 1);
        release_half(1'b0);
        wait_idle(); #2;
        for (int b = 0; b < 4; b++) chk($sformatf("t3_tile2_b%0d", b), mem[b][0], 64'h308 + 64'(b));
        send_cfg(1, 2);
        for (int b = 0; b < 4; b++) send_beat(64'h30C + 64'(b), 1'b0);
        @(negedge clk);
        chk("t3_set_wins_ready", s_act_ready, 0);
        chk("t3_set_wins_busy", busy, 1);

        // 4: early s_act_last leaves partial pointers visible while waiting
        do_reset(); send_cfg(4, 3); clr_mon();
        send_beat(64'h400, 1'b1);
        send_beat(64'h401, 1'b0);
        send_beat(64'h402, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("t4_wait_ready", s_act_ready, 0);
        chk("t4_ptr0", write_addr_pingpong_data[0], 5'b10001);
        chk("t4_ptr1", write_addr_pingpong_data[1], 5'b10001);
        chk("t4_ptr2", write_addr_pingpong_data[2], 5'b10000);
        chk("t4_ptr3", write_addr_pingpong_data[3], 5'b10000);
        release_half(1'b0);
        chk("t4_resume_ready", s_act_ready, 1);
        for (int b = 0; b < 4; b++) chk($sformatf("t4_flip_ptr%0d", b), write_addr_pingpong_data[b], 0);
        send_beat(64'h403, 1'b1);
        wait_idle(); #2;
        chk("t4_mem_b0_h1", mem[0][1], 64'h401);
        chk("t4_mem_b1_h1", mem[1][1], 64'h402);
        chk("t4_mem_b0_h0", mem[0][0], 64'h403);
        chk("t4_done_count", done_count, 3);

        // 5: full-depth tile
        do_reset(); send_cfg(16, 1); clr_mon();
        for (int i = 0; i < 60; i++) send_beat(64'h500 + 64'(i), 1'b0);
        repeat (3) @(negedge clk);
        for (int b = 0; b < 4; b++) chk($sformatf("t5_ptr15_%0d", b), write_addr_pingpong_data[b], 5'd15);
        for (int i = 60; i < 64; i++) send_beat(64'h500 + 64'(i), 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        #2;
        for (int b = 0; b < 4; b++) chk($sformatf("t5_ptr_flip%0d", b), write_addr_pingpong_data[b], 5'b10000);
        chk("t5_wr_count", wr_count, 64);
        chk("t5_done_count", done_count, 1);
        chk("t5_mem_b0_a15", mem[0][30], 64'h500 + 64'd60);
        chk("t5_mem_b3_a15", mem[3][30], 64'h500 + 64'd63);
        chk("t5_mem_b2_a0", mem[2][0], 64'h502);

        // 6: reset in the middle of a tile
        do_reset(); send_cfg(1, 3);
        for (int b = 0; b < 4; b++) send_beat(64'h600 + 64'(b), 1'b0);
        for (int b = 0; b < 4; b++) send_beat(64'h604 + 64'(b), 1'b0);
        @(negedge clk);
        release_half(1'b0);
        for (int b = 0; b < 3; b++) send_beat(64'h608 + 64'(b), 1'b0);
        s_act_valid = 1'b1; s_act_data = 64'h60B; rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_ena", enaA, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", s_act_ready, 0);
        chk("t6_rst_done", tile_done, 0);
        for (int b = 0; b < 4; b++) chk($sformatf("t6_rst_ptr%0d", b), write_addr_pingpong_data[b], 0);
        rst = 1'b0; s_act_valid = 1'b0;
        @(negedge clk);
        send_cfg(1, 2);
        send_beat(64'h6A0, 1'b0);
        chk("t6_first_ena", enaA, 4'h1);
        chk("t6_first_addr", addrA_ping_pong, 5'd0);
        chk("t6_first_di", diA, 64'h6A0);
        for (int b = 1; b < 4; b++) send_beat(64'h6A0 + 64'(b), 1'b0);
        @(negedge clk);
        chk("t6_half1_free", s_act_ready, 1);
        for (int b = 0; b < 4; b++) send_beat(64'h6A4 + 64'(b), 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
